// File: rtl/button_debounce_array_if.sv
// Signal bundle for button_debounce_array: raw buttons in, conditioned levels and pulses out.
// There is no valid/ready handshake: every output is a registered level or pulse that is valid
// every cycle after the rising clk edge, and btn_in may change at any time (it is asynchronous).
interface button_debounce_array_if #(
  parameter int CH = 5
);
  logic [CH-1:0]   btn_in;
  logic [CH-1:0]   btn_level;
  logic [CH-1:0]   pos_pulse;
  logic [CH-1:0]   neg_pulse;
  logic [CH-1:0]   rep_pulse;
  logic [2*CH-1:0] dbg_state;  // per-channel debounce FSM state, channel i at [2*i +: 2]

  modport master (
    output btn_in,
    input  btn_level, pos_pulse, neg_pulse, rep_pulse, dbg_state
  );

  modport slave (
    input  btn_in,
    output btn_level, pos_pulse, neg_pulse, rep_pulse, dbg_state
  );
endinterface

// File: rtl/button_debounce_array.sv
// N-channel push-button conditioner: synchroniser, debounce FSM, level plus edge pulses.
// Optional HOLD_REPEAT_EN macro adds an auto-repeat pulse while a button is held high.
module button_debounce_array #(
  parameter int CH           = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE     = 130000,
  parameter int CNT_W        = 17,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PER   = 10000000
) (
  input logic                          clk,
  input logic                          buttom_rst,
  button_debounce_array_if.slave       bus
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_t;

  localparam logic [CNT_W-1:0] DB_CNT  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CH-1:0]   level_v;
  logic [CH-1:0]   pos_v;
  logic [CH-1:0]   neg_v;
  logic [CH-1:0]   rep_v;
  logic [2*CH-1:0] dbg_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pos_q, pos_d;
    logic                   neg_q, neg_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge buttom_rst) begin
      if (!buttom_rst) begin
        sync_q  <= '0;
        state_q <= STABLE_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.btn_in[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pos_q   <= pos_d;
        neg_q   <= neg_d;
      end
    end

    // The candidate sample loads cnt=1, so accepting at cnt==DEBOUNCE needs DEBOUNCE+1 samples.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
      case (state_q)
        STABLE_LOW: begin
          if (s) begin
            state_d = CHK_HIGH;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == DB_CNT) begin
            state_d = STABLE_HIGH;
            level_d = 1'b1;
            pos_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state_d = CHK_LOW;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        CHK_LOW: begin
          if (s) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == DB_CNT) begin
            state_d = STABLE_LOW;
            level_d = 1'b0;
            neg_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    assign level_v[i]        = level_q;
    assign pos_v[i]          = pos_q;
    assign neg_v[i]          = neg_q;
    assign dbg_v[2*i +: 2]   = state_q;

`ifdef HOLD_REPEAT_EN
    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PER_LAST   = 32'(REPEAT_PER - 1);

    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_first_q, rep_first_d;
    logic        rep_q, rep_d;

    always_ff @(posedge clk or negedge buttom_rst) begin
      if (!buttom_rst) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
        rep_q       <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_first_q <= rep_first_d;
        rep_q       <= rep_d;
      end
    end

    // Counting only while the channel stays in STABLE_HIGH; anything else re-arms the delay.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_d       = 1'b0;
      if (state_q == STABLE_HIGH && s) begin
        if (rep_cnt_q == (rep_first_q ? DELAY_LAST : PER_LAST)) begin
          rep_d       = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 32'd1;
        end
      end else begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end
    end

    assign rep_v[i] = rep_q;
`else
    assign rep_v[i] = 1'b0;
`endif
  end

  assign bus.btn_level = level_v;
  assign bus.pos_pulse = pos_v;
  assign bus.neg_pulse = neg_v;
`ifdef HOLD_REPEAT_EN
  assign bus.rep_pulse = rep_v;
`else
  assign bus.rep_pulse = {CH{1'b0}} & rep_v;
`endif
  assign bus.dbg_state = dbg_v;

endmodule

// File: tb/tb_button_debounce_array.sv
// Bench for button_debounce_array: directed scenarios plus random toggling, checked every
// cycle against a run-length reference model through an expected-value queue.
module tb_button_debounce_array;

  localparam int CH           = 5;
  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE     = 4;
  localparam int CNT_W        = 3;
  localparam int REPEAT_DELAY = 8;
  localparam int REPEAT_PER   = 3;
  localparam int W            = 4 * CH;
  // Negedges from the drive point until the pulse is visible.
  localparam int LAT          = SYNC_STAGES + DEBOUNCE + 1;
`ifdef HOLD_REPEAT_EN
  localparam int EXP_REP = 6;
`else
  localparam int EXP_REP = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic buttom_rst;
  always #5 clk = ~clk;

  button_debounce_array_if #(.CH(CH)) bus ();

  button_debounce_array #(
    .CH(CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk(clk),
    .buttom_rst(buttom_rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // A button level flips once DEBOUNCE+1 consecutive synchronised samples disagree with it.
  logic [CH-1:0] pipe_q[$];
  int            dis_cnt[CH];
  int            hold_cnt[CH];
  bit            lvl_m[CH];

  always @(posedge clk) begin
    logic [CH-1:0] s_v, e_lvl, e_pos, e_neg, e_rep;
    e_pos = '0;
    e_neg = '0;
    e_rep = '0;
    if (!buttom_rst) begin
      pipe_q.delete();
      for (int k = 0; k < SYNC_STAGES; k++) pipe_q.push_back('0);
      for (int c = 0; c < CH; c++) begin
        dis_cnt[c]  = 0;
        hold_cnt[c] = 0;
        lvl_m[c]    = 1'b0;
      end
    end else begin
      pipe_q.push_back(bus.btn_in);
      s_v = pipe_q.pop_front();
      for (int c = 0; c < CH; c++) begin
        if (s_v[c] != lvl_m[c]) begin
          dis_cnt[c]++;
          hold_cnt[c] = 0;
          if (dis_cnt[c] == DEBOUNCE + 1) begin
            lvl_m[c]   = s_v[c];
            dis_cnt[c] = 0;
            if (s_v[c]) e_pos[c] = 1'b1;
            else        e_neg[c] = 1'b1;
          end
        end else begin
          if (dis_cnt[c] > 0) hold_cnt[c] = 0;
          else if (lvl_m[c]) begin
            hold_cnt[c]++;
`ifdef HOLD_REPEAT_EN
            if (hold_cnt[c] == REPEAT_DELAY ||
                (hold_cnt[c] > REPEAT_DELAY && (hold_cnt[c] - REPEAT_DELAY) % REPEAT_PER == 0))
              e_rep[c] = 1'b1;
`endif
          end
          dis_cnt[c] = 0;
        end
      end
    end
    for (int c = 0; c < CH; c++) e_lvl[c] = lvl_m[c];
    exp_q.push_back({e_rep, e_neg, e_pos, e_lvl});
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rep_pulse, bus.neg_pulse, bus.pos_pulse, bus.btn_level};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got rep/neg/pos/lvl=%b/%b/%b/%b expected %b/%b/%b/%b",
                 $time, got[4*CH-1:3*CH], got[3*CH-1:2*CH], got[2*CH-1:CH], got[CH-1:0],
                 exp[4*CH-1:3*CH], exp[3*CH-1:2*CH], exp[2*CH-1:CH], exp[CH-1:0]);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until the selected pulse shows, bounded by a cycle budget.
  task automatic wait_pulse(input string name, input int ch, input bit is_pos, input int exp_lat);
    int lat;
    lat = -1;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(negedge clk);
      if ((is_pos ? bus.pos_pulse[ch] : bus.neg_pulse[ch]) === 1'b1) begin
        lat = c;
        break;
      end
    end
    check(name, lat, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rep_seen;
    buttom_rst = 1'b0;
    bus.btn_in = '0;
    cycles(3);
    buttom_rst = 1'b1;

    // 1: idle after reset
    cycles(20);
    check("t1_idle_outputs", {bus.rep_pulse, bus.neg_pulse, bus.pos_pulse, bus.btn_level}, 0);

    // 2: clean press on channel 0
    bus.btn_in[0] = 1'b1;
    wait_pulse("t2_pos_latency", 0, 1'b1, LAT);
    check("t2_only_ch0_pulses", bus.pos_pulse, 5'b00001);
    cycles(8);
    check("t2_level0", bus.btn_level[0], 1);

    // 3: short glitch on channel 1
    bus.btn_in[1] = 1'b1;
    cycles(3);
    bus.btn_in[1] = 1'b0;
    cycles(12);
    check("t3_level1_low", bus.btn_level[1], 0);

    // 4: release on channel 3
    bus.btn_in[3] = 1'b1;
    cycles(10);
    check("t4_level3_high", bus.btn_level[3], 1);
    bus.btn_in[3] = 1'b0;
    wait_pulse("t4_neg_latency", 3, 1'b0, LAT);
    cycles(5);
    check("t4_level3_low", bus.btn_level[3], 0);

    // 5: two channels together
    bus.btn_in[2] = 1'b1;
    bus.btn_in[4] = 1'b1;
    wait_pulse("t5_pos2_latency", 2, 1'b0 ^ 1'b1, LAT);
    check("t5_pos4_same_cycle", bus.pos_pulse[4], 1);
    cycles(5);

    // 6: reset in the middle of a count
    bus.btn_in[3] = 1'b1;
    cycles(12);
    bus.btn_in[1] = 1'b1;
    cycles(4);
    #1 buttom_rst = 1'b0;
    #1 check("t6_async_clear", {bus.rep_pulse, bus.neg_pulse, bus.pos_pulse, bus.btn_level}, 0);
    cycles(2);
    buttom_rst = 1'b1;
    wait_pulse("t6_pos1_after_release", 1, 1'b1, LAT);
    check("t6_held_channels_pulse", bus.pos_pulse, 5'b11111);

    // 7: long hold on channel 0 for auto-repeat
    bus.btn_in = '0;
    cycles(15);
    bus.btn_in[0] = 1'b1;
    wait_pulse("t7_pos0", 0, 1'b1, LAT);
    rep_seen = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 22) bus.btn_in[0] = 1'b0;
      if (bus.rep_pulse[0] === 1'b1) rep_seen++;
    end
    check("t7_rep_count", rep_seen, EXP_REP);

    // random toggling: mix of glitches and accepted changes
    for (int it = 0; it < 250; it++) begin
      bus.btn_in = bus.btn_in ^ CH'($urandom_range(0, (1 << CH) - 1));
      if ($urandom_range(0, 5) == 0) cycles($urandom_range(8, 30));
      else                           cycles($urandom_range(1, 7));
    end
    bus.btn_in = '0;
    cycles(20);
    check("end_levels_low", bus.btn_level, 0);
    #1 check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
